// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Handshaked, parametrised data memory for the execution-cycle datapath.
// Accepts one byte-addressed load or store at a time, waits WAIT_STATES
// cycles, then reads or strobe-merges one word of the array. The response is
// held stable until the consumer takes it. Misaligned or out-of-range
// accesses leave the array untouched and respond with rsp_err = 1, data 0.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : block can accept a request this cycle (IDLE only)
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_wstrb  : per-byte store enables (ignored for loads)
//   rsp_valid  : response present
//   rsp_ready  : consumer takes the response
//   rsp_rdata  : load data, or merged word after a store; 0 on error
//   rsp_err    : access was misaligned or out of range
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int B      = $clog2(STRB_W);   // byte-offset bits
    localparam int I      = $clog2(DEPTH);    // word-index bits

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic                write_r;
    logic [I-1:0]        idx_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                err_r;
    logic                accept_s;
    logic                addr_err_s;
    logic [DATA_W-1:0]   word_s;
    logic [DATA_W-1:0]   merged_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Ready depends only on state (and reset), never on req_valid.
    assign req_ready = rst_n & (state_r == ST_IDLE);

    // Request acceptance and address checking: any offset bit or any bit above
    // the word index makes the access illegal.
    always_comb begin
        accept_s   = req_valid & req_ready;
        addr_err_s = (req_addr[B-1:0] != '0) || ((req_addr >> (B + I)) != '0);
    end

    // Current word and the strobe-merged store result for the latched request.
    always_comb begin
        word_s   = mem_r[idx_r];
        merged_s = word_s;
        for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_r[i]) begin
                merged_s[8*i +: 8] = wdata_r[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = word_s[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            write_r   <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            err_r     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r <= req_write;
                        idx_r   <= req_addr[B+I-1:B];
                        wdata_r <= req_wdata;
                        wstrb_r <= req_wstrb;
                        err_r   <= addr_err_s;
                        cnt_r   <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_r;
                    if (err_r) begin
                        rsp_rdata <= '0;
                    end else if (write_r) begin
                        rsp_rdata <= merged_s;
                    end else begin
                        rsp_rdata <= word_s;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Array write: contents are not reset. Reset forces IDLE asynchronously,
    // so a store interrupted before its ACCESS edge never lands.
    always_ff @(posedge clk) begin
        if ((state_r == ST_ACCESS) && write_r && !err_r) begin
            mem_r[idx_r] <= merged_s;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int WS     = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-level reference memory; a byte is "known" once the bench stored it.
    logic [7:0] mdl_byte  [DEPTH*4];
    bit         mdl_known [DEPTH*4];

    data_mem_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed array of 1 KiB; anything unaligned
    // or past the end is an error and changes nothing.
    task automatic mdl_access(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [31:0] rd,
                              output logic [31:0] mask, output bit err);
        err  = (addr % 4 != 0) || (addr >= DEPTH * 4);
        rd   = 32'd0;
        mask = 32'hFFFF_FFFF;
        if (!err) begin
            for (int k = 0; k < 4; k++) begin
                if (w && ws[k]) begin
                    mdl_byte[addr + k]  = wd[8*k +: 8];
                    mdl_known[addr + k] = 1'b1;
                end
                rd[8*k +: 8]   = mdl_byte[addr + k];
                mask[8*k +: 8] = mdl_known[addr + k] ? 8'hFF : 8'h00;
            end
        end
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_before_req", req_ready, 1);
    endtask

    // One full transaction: issue, check latency, check response, optionally
    // stall the consumer for 'hold' cycles, then complete the handshake.
    task automatic xact(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic [31:0] held_rd;
        logic        held_err;
        bit          exp_err;
        int          cyc;
        wait_ready();
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(posedge clk); #1;
        mdl_access(w, addr, wd, ws, exp_rd, mask, exp_err);
        // Noise on the request bus while busy must be ignored.
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            chk("ready_low_busy", req_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, WS + 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata & mask, exp_rd & mask);
        got      = rsp_rdata;
        held_rd  = rsp_rdata;
        held_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, held_rd);
            chk("hold_err", rsp_err, held_err);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("valid_after_hs", rsp_valid, 0);
        chk("err_after_hs", rsp_err, 0);
        chk("ready_after_hs", req_ready, 1);
    endtask

    // Start a store, then pull reset after 'cycles_in' edges past acceptance.
    task automatic store_then_reset(input logic [31:0] addr, input logic [31:0] wd,
                                    input int cycles_in, input string tag);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = wd; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < cycles_in; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, rsp_valid, 0);
        chk({tag, "_rst_rdata"}, rsp_rdata, 0);
        chk({tag, "_rst_err"}, rsp_err, 0);
        chk({tag, "_rst_ready"}, req_ready, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready_after_rst"}, req_ready, 1);
    endtask

    initial begin
        logic [31:0] got;
        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
        for (int a = 0; a < DEPTH * 4; a++) begin
            mdl_known[a] = 1'b0;
            mdl_byte[a]  = 8'd0;
        end

        // Reset state.
        #2;
        chk("reset_valid", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_ready", req_ready, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_out_of_reset", req_ready, 1);

        // Full-word store and load back.
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("load_deadbeef", got, 32'hDEADBEEF);

        // Partial store merges the low half.
        xact(1'b1, 32'h10, 32'h00001122, 4'h3, 0, got);
        chk("store_merge", got, 32'hDEAD1122);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("load_merge", got, 32'hDEAD1122);

        // Error accesses leave the array alone.
        xact(1'b1, 32'h0, 32'h01234567, 4'hF, 0, got);
        xact(1'b0, 32'h13, 32'h0, 4'h0, 0, got);
        chk("misaligned_data", got, 32'h0);
        xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, got);
        chk("oor_data", got, 32'h0);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, got);
        chk("word0_unchanged", got, 32'h01234567);

        // Zero-strobe store is a legal no-op.
        xact(1'b1, 32'h10, 32'h55555555, 4'h0, 0, got);
        chk("zero_strobe", got, 32'hDEAD1122);

        // Consumer backpressure.
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5, got);

        // Reset during WAIT drops the store.
        xact(1'b1, 32'h20, 32'h11112222, 4'hF, 0, got);
        store_then_reset(32'h20, 32'hCAFEF00D, 0, "wait");
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        chk("after_wait_rst", got, 32'h11112222);

        // Reset during ACCESS (before its closing edge) also drops the store.
        xact(1'b1, 32'h24, 32'h55AA55AA, 4'hF, 0, got);
        store_then_reset(32'h24, 32'h0BADC0DE, WS, "access");
        xact(1'b0, 32'h24, 32'h0, 4'h0, 0, got);
        chk("after_access_rst", got, 32'h55AA55AA);

        // Sweep: random-strobe store to every word, then load every word.
        for (int i = 0; i < DEPTH; i++) begin
            xact(1'b1, 32'(i * 4), $urandom, 4'($urandom_range(0, 15)), 0, got);
        end
        for (int i = 0; i < DEPTH; i++) begin
            xact(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
